ap_ctrl_sequencer: RTL

//  Initiator side of the ap_ctrl_hs block-level handshake: drives ap_start/ap_continue

---
 rtl/ap_ctrl_sequencer.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ap_ctrl_sequencer.sv
// Purpose : ap_ctrl_hs initiator; issues cfg_num_txn kernel starts with a programmable gap,
//           caps outstanding transactions and reports per-transaction start->done latency.
// Latency : ap_start rises the cycle after go; lat_valid one cycle after the matching ap_done.
// Backpressure: ap_start is held until ap_ready; no new start while MAX_OUTSTANDING are in flight.
//
// Ports:
//   ap_clk, ap_rst_n         clock, asynchronous active-low reset
//   go, cfg_num_txn,         run request (1-cycle pulse) and its configuration,
//   cfg_start_gap            latched on an accepted go
//   ap_start, ap_continue    to kernel (ap_continue tied high)
//   ap_ready, ap_done        from kernel
//   busy, finish             run in progress / run finished (level until next go)
//   txn_issued, txn_done     per-run transaction counters
//   lat_valid, lat_value     per-transaction latency report
//   total_cycles             go-to-finish cycle count, held after finish
//   err                      sticky error (ap_done with nothing outstanding, or watchdog)
// Build option: define AP_CTRL_SEQ_TIMEOUT_EN to enable the TIMEOUT_CYC watchdog.

module ap_ctrl_sequencer #(
  parameter int CNT_W           = 32,
  parameter int LAT_W           = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYC     = 10000
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             go,
  input  logic [CNT_W-1:0] cfg_num_txn,
  input  logic [15:0]      cfg_start_gap,
  output logic             ap_start,
  output logic             ap_continue,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] txn_issued,
  output logic [CNT_W-1:0] txn_done,
  output logic             lat_valid,
  output logic [LAT_W-1:0] lat_value,
  output logic [LAT_W-1:0] total_cycles,
  output logic             err
);

  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT   = OW'(MAX_OUTSTANDING);
  localparam logic [AW-1:0] LAST_SLOT = AW'(MAX_OUTSTANDING - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [CNT_W-1:0] r_num;
  logic [15:0]      r_gap_cfg;
  logic [15:0]      r_gap_cnt;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_done;
  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] r_total;
  logic             r_finish;
  logic             r_err;
  logic             r_lat_vld;
  logic [LAT_W-1:0] r_lat_val;
  logic             r_start_held;
  logic [LAT_W-1:0] r_ts_held;

  // Issue-timestamp FIFO, in order because ap_ctrl_hs completes in order.
  logic [LAT_W-1:0] r_ts_mem [MAX_OUTSTANDING];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [OW-1:0]    r_out_cnt;

  logic             w_busy;
  logic             w_go_acc;
  logic             w_start;
  logic             w_accept;
  logic             w_done_evt;
  logic             w_fifo_empty;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_done_ok;
  logic             w_done_bad;
  logic             w_last;
  logic             w_enter_fin;
  logic             w_wd_hit;
  logic [LAT_W-1:0] w_ts_now;
  logic [LAT_W-1:0] w_ts_pop;

  assign w_busy       = (r_state == S_ISSUE) || (r_state == S_GAP) || (r_state == S_DRAIN);
  assign w_go_acc     = go && !w_busy;
  // A start already raised is never withdrawn, even if the cap would forbid raising it now.
  assign w_start      = (r_state == S_ISSUE) && (r_start_held || (r_out_cnt < MAX_OUT));
  assign w_accept     = w_start && ap_ready;
  assign w_done_evt   = ap_done && w_busy;
  assign w_fifo_empty = (r_out_cnt == '0);
  // Combinational kernel: ready and done in the same cycle with nothing queued.
  assign w_bypass     = w_done_evt && w_fifo_empty && w_accept;
  assign w_pop        = w_done_evt && !w_fifo_empty;
  assign w_push       = w_accept && !w_bypass;
  assign w_done_ok    = w_pop || w_bypass;
  assign w_done_bad   = w_done_evt && w_fifo_empty && !w_accept;
  assign w_last       = ((r_issued + CNT_W'(1)) == r_num);
  assign w_enter_fin  = w_busy && (w_next == S_FIN);
  // Timestamp is the counter on the first cycle this start was asserted.
  assign w_ts_now     = r_start_held ? r_ts_held : r_cnt;
  assign w_ts_pop     = w_fifo_empty ? w_ts_now : r_ts_mem[r_rd_ptr];

`ifdef AP_CTRL_SEQ_TIMEOUT_EN
  logic [31:0] r_wd_cnt;
  logic        w_wd_active;
  logic        w_wd_evt;

  assign w_wd_active = w_busy && ((r_out_cnt != '0) || w_start);
  assign w_wd_evt    = w_accept || w_done_evt;
  assign w_wd_hit    = w_wd_active && !w_wd_evt && (r_wd_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wd_cnt <= '0;
    end else if (w_go_acc || !w_wd_active || w_wd_evt) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
    end
  end
`else
  assign w_wd_hit = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_FIN: begin
        if (go) begin
          w_next = (cfg_num_txn == '0) ? S_FIN : S_ISSUE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_accept) begin
          if (w_last) begin
            w_next = S_DRAIN;
          end else if (r_gap_cfg != 16'd0) begin
            w_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 16'd0) begin
          w_next = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (w_fifo_empty) begin
          w_next = S_FIN;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_wd_hit) begin
      w_next = S_FIN;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_num        <= '0;
      r_gap_cfg    <= '0;
      r_gap_cnt    <= '0;
      r_issued     <= '0;
      r_done       <= '0;
      r_cnt        <= '0;
      r_total      <= '0;
      r_finish     <= 1'b0;
      r_err        <= 1'b0;
      r_lat_vld    <= 1'b0;
      r_lat_val    <= '0;
      r_start_held <= 1'b0;
      r_ts_held    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_out_cnt    <= '0;
    end else begin
      r_lat_vld <= w_done_ok;
      if (w_done_ok) begin
        r_lat_val <= r_cnt - w_ts_pop;
      end
      if (w_done_bad || w_wd_hit) begin
        r_err <= 1'b1;
      end

      if (w_go_acc) begin
        r_num        <= cfg_num_txn;
        r_gap_cfg    <= cfg_start_gap;
        r_gap_cnt    <= '0;
        r_issued     <= '0;
        r_done       <= '0;
        // The go cycle is cycle 0, so the first busy cycle reads 1.
        r_cnt        <= LAT_W'(1);
        r_total      <= (cfg_num_txn == '0) ? LAT_W'(1) : '0;
        r_finish     <= (cfg_num_txn == '0);
        r_start_held <= 1'b0;
        r_ts_held    <= '0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_out_cnt    <= '0;
      end else begin
        if (w_busy) begin
          r_cnt <= r_cnt + LAT_W'(1);
        end
        if (w_accept) begin
          r_issued <= r_issued + CNT_W'(1);
        end
        if (w_done_ok) begin
          r_done <= r_done + CNT_W'(1);
        end
        if (w_enter_fin) begin
          r_finish <= 1'b1;
          r_total  <= r_cnt + LAT_W'(1);
        end

        if (w_accept || w_wd_hit) begin
          r_start_held <= 1'b0;
        end else if (w_start) begin
          r_start_held <= 1'b1;
          r_ts_held    <= w_ts_now;
        end

        // Loaded with gap-1 so the GAP state lasts exactly cfg_start_gap cycles.
        if (w_accept && !w_last && (r_gap_cfg != 16'd0)) begin
          r_gap_cnt <= r_gap_cfg - 16'd1;
        end else if ((r_state == S_GAP) && (r_gap_cnt != 16'd0)) begin
          r_gap_cnt <= r_gap_cnt - 16'd1;
        end

        if (w_push) begin
          r_wr_ptr <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + AW'(1);
        end
        if (w_push && !w_pop) begin
          r_out_cnt <= r_out_cnt + OW'(1);
        end else if (w_pop && !w_push) begin
          r_out_cnt <= r_out_cnt - OW'(1);
        end
      end
    end
  end

  // Storage only; occupancy is tracked by the reset pointers and count.
  always_ff @(posedge ap_clk) begin
    if (w_push) begin
      r_ts_mem[r_wr_ptr] <= w_ts_now;
    end
  end

  assign ap_start     = w_start;
  assign ap_continue  = 1'b1;
  assign busy         = w_busy;
  assign finish       = r_finish;
  assign txn_issued   = r_issued;
  assign txn_done     = r_done;
  assign lat_valid    = r_lat_vld;
  assign lat_value    = r_lat_val;
  assign total_cycles = r_total;
  assign err          = r_err;

endmodule
